// File: rtl/mult_div_pkg.sv
// Shared types and helpers for the iterative multiply/divide sequencer.
package mult_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  // Widest vector the negate helper handles; callers zero-extend in and truncate out,
  // which is exact for two's complement, so WIDTH up to MAX_W/2 is supported.
  localparam int MAX_W = 128;

  function automatic logic [MAX_W-1:0] cond_neg(input logic [MAX_W-1:0] v, input logic en);
    return en ? (~v + MAX_W'(1)) : v;
  endfunction

endpackage

// File: rtl/mult_div_seq_if.sv
// Request/result bundle between the control FSM (master) and the mult/div unit (slave).
interface mult_div_seq_if #(
  parameter int WIDTH = 32
) ();

  logic             start;
  logic             op;
  logic             signed_op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             busy;
  logic             done;
  logic             div0;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, signed_op, a, b, flush,
    input  busy, done, div0, hi, lo
  );

  modport slave (
    input  start, op, signed_op, a, b, flush,
    output busy, done, div0, hi, lo
  );

endinterface

// File: rtl/mult_div_step.sv
// One iteration of the datapath: shift-add for multiply, restoring shift-subtract for divide.
module mult_div_step
  import mult_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   opnd_i,
  input  logic               op_i,
  output logic [2*WIDTH-1:0] acc_o,
  output logic               q_bit_o
);

  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] rem_next;

  // Multiply: acc = {partial product, remaining multiplier bits}; the carry of the
  // add shifts into the top, so W+1 bits of sum plus W-1 multiplier bits fill 2W.
  // Divide: acc = {partial remainder, remaining dividend / quotient bits}.
  always_comb begin
    addend   = acc_i[0] ? opnd_i : {WIDTH{1'b0}};
    sum      = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    trial    = acc_i[2*WIDTH-1:WIDTH-1] - {1'b0, opnd_i};
    rem_next = trial[WIDTH] ? acc_i[2*WIDTH-2:WIDTH-1] : trial[WIDTH-1:0];
    if (op_i == OP_DIV) begin
      acc_o   = {rem_next, acc_i[WIDTH-2:0], 1'b0};
      q_bit_o = ~trial[WIDTH];
    end else begin
      acc_o   = {sum, acc_i[WIDTH-1:1]};
      q_bit_o = 1'b0;
    end
  end

endmodule

// File: rtl/mult_div_seq.sv
// Iterative signed/unsigned multiply/divide sequencer driving the HI/LO registers.
// Magnitudes are iterated for WIDTH cycles, then sign-corrected in a single FIX cycle.
module mult_div_seq
  import mult_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           reset,
  mult_div_seq_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int PW    = 2 * WIDTH;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic             op_q, op_d;
  logic             neg_hi_q, neg_hi_d;
  logic             neg_lo_q, neg_lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, done_q, div0_q, div0_d;

  logic             sign_a, sign_b;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [PW-1:0]    step_acc, step_next;
  logic             step_q;
  logic [PW-1:0]    prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  assign sign_a = bus.signed_op & bus.a[WIDTH-1];
  assign sign_b = bus.signed_op & bus.b[WIDTH-1];
  // |min| = 2^(W-1) is representable as an unsigned magnitude, so no overflow case here.
  assign mag_a  = WIDTH'(cond_neg(MAX_W'(bus.a), sign_a));
  assign mag_b  = WIDTH'(cond_neg(MAX_W'(bus.b), sign_b));

  mult_div_step #(.WIDTH(WIDTH)) u_step (
    .acc_i   (acc_q),
    .opnd_i  (opnd_q),
    .op_i    (op_q),
    .acc_o   (step_acc),
    .q_bit_o (step_q)
  );

  assign step_next = {step_acc[PW-1:1], (op_q == OP_DIV) ? step_q : step_acc[0]};

  assign prod_fix = PW'(cond_neg(MAX_W'(acc_q), neg_lo_q));
  assign quo_fix  = WIDTH'(cond_neg(MAX_W'(acc_q[WIDTH-1:0]), neg_lo_q));
  assign rem_fix  = WIDTH'(cond_neg(MAX_W'(acc_q[PW-1:WIDTH]), neg_hi_q));

  // NOTE: every variable gets its hold value first, so no path through the case
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    op_d     = op_q;
    neg_hi_d = neg_hi_q;
    neg_lo_d = neg_lo_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    div0_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!bus.flush && bus.start) begin
          if (bus.op == OP_DIV && bus.b == '0) begin
            state_d = DONE;
            div0_d  = 1'b1;
          end else begin
            state_d = RUN;
            op_d    = bus.op;
            cnt_d   = CNT_W'(WIDTH);
            if (bus.op == OP_MULT) begin
              acc_d    = {{WIDTH{1'b0}}, mag_b};
              opnd_d   = mag_a;
              neg_hi_d = sign_a ^ sign_b;
              neg_lo_d = sign_a ^ sign_b;
            end else begin
              acc_d    = {{WIDTH{1'b0}}, mag_a};
              opnd_d   = mag_b;
              neg_hi_d = sign_a;
              neg_lo_d = sign_a ^ sign_b;
            end
          end
        end
      end
      RUN: begin
        if (bus.flush) begin
          state_d = IDLE;
        end else begin
          acc_d = step_next;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = FIX;
        end
      end
      FIX: begin
        if (bus.flush) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
          if (op_q == OP_MULT) begin
            {hi_d, lo_d} = prod_fix;
          end else begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update
  // from the same pre-edge values. The datapath registers are reset too: they are
  // few, and a clean reset state keeps hi/lo and the counter deterministic.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      op_q     <= OP_MULT;
      neg_hi_q <= 1'b0;
      neg_lo_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      div0_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      op_q     <= op_d;
      neg_hi_q <= neg_hi_d;
      neg_lo_q <= neg_lo_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= (state_d == RUN) || (state_d == FIX);
      done_q   <= (state_d == DONE);
      div0_q   <= div0_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.div0 = div0_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mult_div_seq.sv
// Directed-vector bench for mult_div_seq at WIDTH = 32 and WIDTH = 8.
module tb_mult_div_seq;
  import mult_div_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  mult_div_seq_if #(.WIDTH(32)) bus32 ();
  mult_div_seq_if #(.WIDTH(8))  bus8 ();

  mult_div_seq #(.WIDTH(32)) dut32 (.clk(clk), .reset(rst_n), .bus(bus32.slave));
  mult_div_seq #(.WIDTH(8))  dut8  (.clk(clk), .reset(rst_n), .bus(bus8.slave));

  typedef struct {
    logic        op;
    logic        sg;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  // Issue one request and observe 45 cycles; n counts cycles after the sampling edge.
  // poke_n injects a stray start (50*5 mult) in cycle n, flush_n a one-cycle flush.
  task automatic run32(input logic op, input logic sg, input logic [31:0] av, input logic [31:0] bv,
                       input int poke_n, input int flush_n,
                       output int done_n, output int done_cnt, output int busy_cnt,
                       output int busy_first, output int div0_cnt);
    done_n = -1; done_cnt = 0; busy_cnt = 0; busy_first = -1; div0_cnt = 0;
    @(negedge clk);
    bus32.start = 1'b1; bus32.op = op; bus32.signed_op = sg; bus32.a = av; bus32.b = bv;
    @(negedge clk);
    bus32.start = 1'b0;
    for (int n = 1; n <= 45; n++) begin
      if (bus32.busy) begin busy_cnt++; if (busy_first < 0) busy_first = n; end
      if (bus32.done) begin done_cnt++; done_n = n; end
      if (bus32.div0) div0_cnt++;
      bus32.start = (n == poke_n);
      if (n == poke_n) begin
        bus32.op = OP_MULT; bus32.signed_op = 1'b0; bus32.a = 32'd50; bus32.b = 32'd5;
      end
      bus32.flush = (n == flush_n);
      @(negedge clk);
    end
  endtask

  task automatic run8(input logic op, input logic sg, input logic [7:0] av, input logic [7:0] bv,
                      output int done_n, output int done_cnt, output int busy_cnt);
    done_n = -1; done_cnt = 0; busy_cnt = 0;
    @(negedge clk);
    bus8.start = 1'b1; bus8.op = op; bus8.signed_op = sg; bus8.a = av; bus8.b = bv;
    @(negedge clk);
    bus8.start = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      if (bus8.busy) busy_cnt++;
      if (bus8.done) begin done_cnt++; done_n = n; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    n_cmp++; if (bus32.busy !== 1'b0) begin n_bad++; $display("FAIL reset busy: got %b want 0", bus32.busy); end
    n_cmp++; if (bus32.done !== 1'b0) begin n_bad++; $display("FAIL reset done: got %b want 0", bus32.done); end
    n_cmp++; if (bus32.div0 !== 1'b0) begin n_bad++; $display("FAIL reset div0: got %b want 0", bus32.div0); end
    n_cmp++; if (bus32.hi !== 32'h0) begin n_bad++; $display("FAIL reset hi: got %h want 0", bus32.hi); end
    n_cmp++; if (bus32.lo !== 32'h0) begin n_bad++; $display("FAIL reset lo: got %h want 0", bus32.lo); end
    n_cmp++; if ({bus8.hi, bus8.lo, bus8.busy} !== 17'h0) begin n_bad++; $display("FAIL reset w8: got %h want 0", {bus8.hi, bus8.lo, bus8.busy}); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if ({bus32.busy, bus32.done} !== 2'b00) begin n_bad++; $display("FAIL post-reset idle: got %b want 00", {bus32.busy, bus32.done}); end
  endtask

  task automatic test_mult();
    vec_t v[4];
    int dn, dc, bc, bf, d0;
    v[0] = '{OP_MULT, 1'b1, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
    v[1] = '{OP_MULT, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    v[2] = '{OP_MULT, 1'b1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    v[3] = '{OP_MULT, 1'b0, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780};
    for (int i = 0; i < 4; i++) begin
      run32(v[i].op, v[i].sg, v[i].a, v[i].b, 0, 0, dn, dc, bc, bf, d0);
      n_cmp++; if (bus32.hi !== v[i].hi) begin n_bad++; $display("FAIL mult[%0d] hi: got %h want %h", i, bus32.hi, v[i].hi); end
      n_cmp++; if (bus32.lo !== v[i].lo) begin n_bad++; $display("FAIL mult[%0d] lo: got %h want %h", i, bus32.lo, v[i].lo); end
      n_cmp++; if (dn !== 34) begin n_bad++; $display("FAIL mult[%0d] done cycle: got %0d want 34", i, dn); end
      n_cmp++; if (dc !== 1) begin n_bad++; $display("FAIL mult[%0d] done pulses: got %0d want 1", i, dc); end
      n_cmp++; if (bc !== 33 || bf !== 1) begin n_bad++; $display("FAIL mult[%0d] busy: got %0d cycles from %0d want 33 from 1", i, bc, bf); end
      n_cmp++; if (d0 !== 0) begin n_bad++; $display("FAIL mult[%0d] div0: got %0d want 0", i, d0); end
    end
  endtask

  task automatic test_div();
    vec_t v[5];
    int dn, dc, bc, bf, d0;
    v[0] = '{OP_DIV, 1'b1, 32'd100,      32'd7,        32'd2,        32'd14};
    v[1] = '{OP_DIV, 1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
    v[2] = '{OP_DIV, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    v[3] = '{OP_DIV, 1'b0, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF};
    v[4] = '{OP_DIV, 1'b1, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    for (int i = 0; i < 5; i++) begin
      run32(v[i].op, v[i].sg, v[i].a, v[i].b, 0, 0, dn, dc, bc, bf, d0);
      n_cmp++; if (bus32.hi !== v[i].hi) begin n_bad++; $display("FAIL div[%0d] rem: got %h want %h", i, bus32.hi, v[i].hi); end
      n_cmp++; if (bus32.lo !== v[i].lo) begin n_bad++; $display("FAIL div[%0d] quo: got %h want %h", i, bus32.lo, v[i].lo); end
      n_cmp++; if (dn !== 34 || dc !== 1) begin n_bad++; $display("FAIL div[%0d] done: got %0d pulses at %0d want 1 at 34", i, dc, dn); end
      n_cmp++; if (bc !== 33 || d0 !== 0) begin n_bad++; $display("FAIL div[%0d] busy/div0: got %0d/%0d want 33/0", i, bc, d0); end
    end
  endtask

  task automatic test_div0();
    int dn, dc, bc, bf, d0;
    run32(OP_DIV, 1'b1, 32'd100, 32'd7, 0, 0, dn, dc, bc, bf, d0);
    run32(OP_DIV, 1'b1, 32'd123, 32'd0, 0, 0, dn, dc, bc, bf, d0);
    n_cmp++; if (dn !== 1 || dc !== 1) begin n_bad++; $display("FAIL div0 done: got %0d pulses at %0d want 1 at 1", dc, dn); end
    n_cmp++; if (d0 !== 1) begin n_bad++; $display("FAIL div0 flag: got %0d pulses want 1", d0); end
    n_cmp++; if (bc !== 0) begin n_bad++; $display("FAIL div0 busy: got %0d cycles want 0", bc); end
    n_cmp++; if (bus32.hi !== 32'd2 || bus32.lo !== 32'd14) begin n_bad++; $display("FAIL div0 hold: got %h/%h want 2/e", bus32.hi, bus32.lo); end
    run32(OP_DIV, 1'b0, 32'd9, 32'd0, 0, 0, dn, dc, bc, bf, d0);
    n_cmp++; if (dn !== 1 || d0 !== 1 || bus32.lo !== 32'd14) begin n_bad++; $display("FAIL divu0: got done@%0d div0=%0d lo=%h want 1/1/e", dn, d0, bus32.lo); end
  endtask

  task automatic test_back_to_back();
    int dn, dc, bc, bf, d0;
    run32(OP_DIV, 1'b1, 32'd100, 32'd7, 5, 0, dn, dc, bc, bf, d0);
    n_cmp++; if (bus32.hi !== 32'd2 || bus32.lo !== 32'd14) begin n_bad++; $display("FAIL start-in-run result: got %h/%h want 2/e", bus32.hi, bus32.lo); end
    n_cmp++; if (dn !== 34 || dc !== 1 || bc !== 33) begin n_bad++; $display("FAIL start-in-run timing: got done %0d@%0d busy %0d want 1@34 busy 33", dc, dn, bc); end
    run32(OP_MULT, 1'b1, 32'hFFFFFFFD, 32'd7, 34, 0, dn, dc, bc, bf, d0);
    n_cmp++; if (bus32.hi !== 32'hFFFFFFFF || bus32.lo !== 32'hFFFFFFEB) begin n_bad++; $display("FAIL start-in-done result: got %h/%h want ffffffff/ffffffeb", bus32.hi, bus32.lo); end
    n_cmp++; if (dc !== 1 || bc !== 33) begin n_bad++; $display("FAIL start-in-done queued: got %0d pulses busy %0d want 1/33", dc, bc); end
  endtask

  task automatic test_flush();
    int dn, dc, bc, bf, d0;
    int seen;
    run32(OP_DIV, 1'b1, 32'd100, 32'd7, 0, 0, dn, dc, bc, bf, d0);
    run32(OP_MULT, 1'b0, 32'h12345678, 32'd9, 0, 10, dn, dc, bc, bf, d0);
    n_cmp++; if (bc !== 10) begin n_bad++; $display("FAIL flush-run busy: got %0d cycles want 10", bc); end
    n_cmp++; if (dc !== 0) begin n_bad++; $display("FAIL flush-run done: got %0d pulses want 0", dc); end
    n_cmp++; if (bus32.hi !== 32'd2 || bus32.lo !== 32'd14) begin n_bad++; $display("FAIL flush-run hold: got %h/%h want 2/e", bus32.hi, bus32.lo); end
    run32(OP_MULT, 1'b0, 32'h12345678, 32'd9, 0, 33, dn, dc, bc, bf, d0);
    n_cmp++; if (bc !== 33 || dc !== 0) begin n_bad++; $display("FAIL flush-fix: got busy %0d done %0d want 33/0", bc, dc); end
    n_cmp++; if (bus32.hi !== 32'd2 || bus32.lo !== 32'd14) begin n_bad++; $display("FAIL flush-fix hold: got %h/%h want 2/e", bus32.hi, bus32.lo); end
    @(negedge clk);
    bus32.start = 1'b1; bus32.flush = 1'b1; bus32.op = OP_DIV; bus32.signed_op = 1'b0;
    bus32.a = 32'd5; bus32.b = 32'd0;
    @(negedge clk);
    bus32.start = 1'b0; bus32.flush = 1'b0;
    seen = 0;
    for (int n = 1; n <= 4; n++) begin
      if (bus32.busy || bus32.done || bus32.div0) seen++;
      @(negedge clk);
    end
    n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL flush-over-start: got %0d active cycles want 0", seen); end
  endtask

  task automatic test_reset_mid();
    int dn, dc, bc, bf, d0;
    @(negedge clk);
    bus32.start = 1'b1; bus32.op = OP_MULT; bus32.signed_op = 1'b1;
    bus32.a = 32'hFFFFFFFD; bus32.b = 32'd7;
    @(negedge clk);
    bus32.start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({bus32.busy, bus32.done, bus32.div0} !== 3'b000) begin n_bad++; $display("FAIL mid-reset flags: got %b want 000", {bus32.busy, bus32.done, bus32.div0}); end
    n_cmp++; if (bus32.hi !== 32'h0 || bus32.lo !== 32'h0) begin n_bad++; $display("FAIL mid-reset hi/lo: got %h/%h want 0/0", bus32.hi, bus32.lo); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dc = 0;
    for (int n = 0; n < 40; n++) begin
      if (bus32.done || bus32.busy) dc++;
      @(negedge clk);
    end
    n_cmp++; if (dc !== 0) begin n_bad++; $display("FAIL mid-reset resumed: got %0d active cycles want 0", dc); end
    run32(OP_MULT, 1'b1, 32'hFFFFFFFD, 32'd7, 0, 0, dn, dc, bc, bf, d0);
    n_cmp++; if (bus32.hi !== 32'hFFFFFFFF || bus32.lo !== 32'hFFFFFFEB || dn !== 34) begin n_bad++; $display("FAIL post-reset op: got %h/%h@%0d want ffffffff/ffffffeb@34", bus32.hi, bus32.lo, dn); end
  endtask

  task automatic test_width8();
    int dn, dc, bc;
    run8(OP_MULT, 1'b1, 8'h80, 8'hFF, dn, dc, bc);
    n_cmp++; if (bus8.hi !== 8'h00 || bus8.lo !== 8'h80) begin n_bad++; $display("FAIL w8 smul: got %h/%h want 00/80", bus8.hi, bus8.lo); end
    n_cmp++; if (dn !== 10 || dc !== 1 || bc !== 9) begin n_bad++; $display("FAIL w8 timing: got done %0d@%0d busy %0d want 1@10 busy 9", dc, dn, bc); end
    run8(OP_MULT, 1'b0, 8'hFF, 8'hFF, dn, dc, bc);
    n_cmp++; if (bus8.hi !== 8'hFE || bus8.lo !== 8'h01) begin n_bad++; $display("FAIL w8 umul: got %h/%h want fe/01", bus8.hi, bus8.lo); end
    run8(OP_DIV, 1'b1, 8'h80, 8'hFF, dn, dc, bc);
    n_cmp++; if (bus8.hi !== 8'h00 || bus8.lo !== 8'h80) begin n_bad++; $display("FAIL w8 min/-1: got %h/%h want 00/80", bus8.hi, bus8.lo); end
    run8(OP_DIV, 1'b1, 8'hF3, 8'd4, dn, dc, bc);
    n_cmp++; if (bus8.hi !== 8'hFF || bus8.lo !== 8'hFD) begin n_bad++; $display("FAIL w8 sdiv: got %h/%h want ff/fd", bus8.hi, bus8.lo); end
  endtask

  initial begin
    bus32.start = 1'b0; bus32.op = OP_MULT; bus32.signed_op = 1'b0;
    bus32.a = '0; bus32.b = '0; bus32.flush = 1'b0;
    bus8.start = 1'b0; bus8.op = OP_MULT; bus8.signed_op = 1'b0;
    bus8.a = '0; bus8.b = '0; bus8.flush = 1'b0;
    test_reset();
    test_mult();
    test_div();
    test_div0();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_width8();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/mult_div_seq.md
Name: mult_div_seq

Overview:
Iterative multiply/divide sequencer feeding the HI/LO registers of the multicycle CPU. It replaces the fixed 32-bit MULT/DIV paths with a WIDTH-parametrised unit supporting signed and unsigned modes. It uses a start/busy/done handshake that the control FSM waits on. It also detects divide-by-zero and supports a flush for exception entry.

Parameters:
WIDTH, 32, operand width; product and quotient/remainder width derived from it (WIDTH >= 4, even).

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous active-low reset
start  input  1  request, sampled only in IDLE
op  input  1  0 = multiply, 1 = divide
signed_op  input  1  1 = two's-complement operands (MULT/DIV), 0 = unsigned (MULTU/DIVU)
a  input  WIDTH  multiplicand / dividend, sampled with start
b  input  WIDTH  multiplier / divisor, sampled with start
flush  input  1  abort current operation (exception entry)
busy  output  1  high in RUN and FIX
done  output  1  one-cycle pulse: result valid
div0  output  1  one-cycle pulse with done: divisor was zero
hi  output  WIDTH  mult: product[2W-1:W]; div: remainder
lo  output  WIDTH  mult: product[W-1:0]; div: quotient

Behaviour:
- Reset (async, reset low): state = IDLE; busy = 0, done = 0, div0 = 0, hi = 0, lo = 0, internal iteration counter = 0.
- States: IDLE, RUN, FIX, DONE.
- IDLE transitions on start = 1:
  - op = 1 and b == 0: go to DONE. On the next cycle done = 1, div0 = 1, hi/lo unchanged.
  - Otherwise: latch |a|, |b| (magnitudes when signed_op, raw otherwise). Latch result-sign flags. Counter = WIDTH. Go to RUN.
- RUN: one iteration per cycle, counter decrements; after WIDTH cycles go to FIX.
  - Multiply: unsigned shift-add on magnitudes into a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract on magnitudes; one quotient bit per cycle.
- FIX: apply two's-complement negation where required, then go to DONE.
  - Product negated if sign(a) ^ sign(b).
  - Quotient negated if sign(a) ^ sign(b).
  - Remainder takes the sign of the dividend.
  - Unsigned mode: no correction.
- DONE: hi/lo registered; done = 1 for exactly this cycle; return to IDLE.
- Latency: start sampled at edge t gives done high in cycle t+WIDTH+2. Divide-by-zero gives done in cycle t+1.
- Result hold: hi/lo hold their value until the next DONE. They are not updated on div0 or flush.
- start while busy or in DONE: ignored, no queueing.
- flush: in any non-IDLE state, next state = IDLE, busy = 0, no done pulse, hi/lo unchanged. In IDLE, flush has priority over start.
- Signed corner cases:
  - DIV min / -1: quotient wraps to min, remainder 0, no flag.
  - MULT min * min: product = 2^(2W-2) (hi = 0x4000…0, lo = 0).
- Reset asserted mid-operation: immediate return to reset values; no done pulse.
- busy is a registered output, high from cycle t+1 through the FIX cycle.

Decomposition:
- Package mult_div_pkg holds:
  - state enum (IDLE, RUN, FIX, DONE)
  - op encoding constants OP_MULT = 1'b0, OP_DIV = 1'b1
  - a function for WIDTH-generic two's-complement negate/abs.
- One sub-module is natural: mult_div_step. It is the combinational single-iteration datapath: given accumulator, operand and op, it returns the next accumulator and quotient bit. It is instantiated once in mult_div_seq.

Test Plan:
- Signed MULT a = 0xFFFFFFFD (-3), b = 7, start at t → busy t+1..t+33, done at t+34 only, hi = 0xFFFFFFFF, lo = 0xFFFFFFEB.
- Unsigned MULT a = b = 0xFFFFFFFF → hi = 0xFFFFFFFE, lo = 0x00000001; signed MULT 0x80000000 * 0x80000000 → hi = 0x40000000, lo = 0.
- Signed DIV 100 / 7 → lo = 14, hi = 2; signed DIV -7 / 2 → lo = 0xFFFFFFFD, hi = 0xFFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF signed → lo = 0x80000000, hi = 0.
- DIV any / 0 → done = div0 = 1 at t+1, busy never high, hi/lo retain previous result.
- Second start during RUN ignored (result matches first operands); flush at t+10 → busy drops at t+11, no done, hi/lo unchanged; reset pulled low at t+5 → all outputs 0 immediately, next start behaves normally.
- Re-run at WIDTH = 8: signed MULT 0x80 * 0xFF → hi = 0x00, lo = 0x80, done at t+10.
